// File: rtl/puf_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : puf_sequencer_if
//  Purpose  : Bundles the sweep-control, PUF datapath, result handshake and
//             status signals of puf_sequencer.
//             Names carry the sequencer's direction (i_ into it, o_ out of it).
//  Modports : master - the sequencer itself
//             slave  - the environment (sweep requester, PUF, result sink)
//  Revision : 1.0 - initial release
// ============================================================================
interface puf_sequencer_if;
  // sweep request
  logic       i_start;
  logic [7:0] i_start_chal;
  logic [7:0] i_num_chal;
  // PUF datapath
  logic       o_puf_reset;
  logic [7:0] o_puf_challenge;
  logic [7:0] i_puf_response;
  logic       i_puf_done;
  // result handshake
  logic       o_resp_valid;
  logic       i_resp_ready;
  logic [7:0] o_resp_chal;
  logic [7:0] o_resp_data;
  logic       o_resp_err;
  // status
  logic       o_busy;
  logic       o_seq_done;
  logic       o_err;
  logic [7:0] o_signature;

  modport master (
    input  i_start, i_start_chal, i_num_chal, i_puf_response, i_puf_done,
           i_resp_ready,
    output o_puf_reset, o_puf_challenge, o_resp_valid, o_resp_chal,
           o_resp_data, o_resp_err, o_busy, o_seq_done, o_err, o_signature
  );

  modport slave (
    output i_start, i_start_chal, i_num_chal, i_puf_response, i_puf_done,
           i_resp_ready,
    input  o_puf_reset, o_puf_challenge, o_resp_valid, o_resp_chal,
           o_resp_data, o_resp_err, o_busy, o_seq_done, o_err, o_signature
  );
endinterface
`default_nettype wire

// File: rtl/puf_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : puf_sequencer
//  Purpose  : Runs a sweep of consecutive PUF challenges. Each challenge is:
//             pulse PUF reset, wait for DONE (or time out), hand the result
//             out over a valid/ready handshake. Transferred responses are
//             XOR-folded into a signature; timeouts set a sticky error flag.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - puf_sequencer_if.master (request, PUF, result, status)
//  Params   : RST_CYC     - PUF reset pulse length in cycles (1..255)
//             TIMEOUT_CYC - maximum cycles waiting for DONE (2..2^24)
//  Revision : 1.0 - initial release
// ============================================================================
module puf_sequencer #(
  parameter int RST_CYC     = 4,
  parameter int TIMEOUT_CYC = 65536
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  puf_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // Both counters count down/up to a "last" value so the phase length equals
  // the parameter exactly.
  localparam logic [7:0]  c_rst_last = 8'(RST_CYC - 1);
  localparam logic [23:0] c_to_last  = 24'(TIMEOUT_CYC - 1);

  state_t      r_state;
  logic        r_puf_reset;
  logic [7:0]  r_chal;
  logic [7:0]  r_remain;      // 0 loaded from NUM_CHAL wraps to 255 -> 256 results
  logic [7:0]  r_rst_cnt;
  logic [23:0] r_wait_cnt;
  logic        r_resp_valid;
  logic [7:0]  r_resp_chal;
  logic [7:0]  r_resp_data;
  logic        r_resp_err;
  logic        r_busy;
  logic        r_seq_done;
  logic        r_err;
  logic [7:0]  r_sig;

  logic [7:0]  w_remain_dec;
  assign w_remain_dec = r_remain - 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_puf_reset  <= 1'b1;
      r_chal       <= 8'h00;
      r_remain     <= 8'h00;
      r_rst_cnt    <= 8'h00;
      r_wait_cnt   <= 24'h0;
      r_resp_valid <= 1'b0;
      r_resp_chal  <= 8'h00;
      r_resp_data  <= 8'h00;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
      r_seq_done   <= 1'b0;
      r_err        <= 1'b0;
      r_sig        <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          // PUF reset held from async reset is released on the first edge.
          r_puf_reset <= 1'b0;
          r_seq_done  <= 1'b0;
          if (bus.i_start) begin
            r_chal      <= bus.i_start_chal;
            r_remain    <= bus.i_num_chal;
            r_sig       <= 8'h00;
            r_err       <= 1'b0;
            r_puf_reset <= 1'b1;
            r_rst_cnt   <= c_rst_last;
            r_busy      <= 1'b1;
            r_state     <= S_RST;
          end
        end

        S_RST: begin
          if (r_rst_cnt == 8'h00) begin
            r_puf_reset <= 1'b0;
            r_wait_cnt  <= 24'h0;
            r_state     <= S_WAIT;
          end else begin
            r_rst_cnt <= r_rst_cnt - 8'd1;
          end
        end

        S_WAIT: begin
          // DONE is tested first so a response arriving in the final timeout
          // cycle still counts as a success.
          if (bus.i_puf_done) begin
            r_resp_data  <= bus.i_puf_response;
            r_resp_chal  <= r_chal;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_OUT;
          end else if (r_wait_cnt == c_to_last) begin
            r_resp_data  <= 8'h00;
            r_resp_chal  <= r_chal;
            r_resp_err   <= 1'b1;
            r_err        <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_OUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 24'd1;
          end
        end

        S_OUT: begin
          if (bus.i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_sig        <= r_sig ^ r_resp_data;
            r_remain     <= w_remain_dec;
            if (w_remain_dec == 8'h00) begin
              r_seq_done <= 1'b1;
              r_state    <= S_FIN;
            end else begin
              // Going straight back to RST keeps results back-to-back.
              r_chal      <= r_chal + 8'd1;
              r_puf_reset <= 1'b1;
              r_rst_cnt   <= c_rst_last;
              r_state     <= S_RST;
            end
          end
        end

        S_FIN: begin
          r_seq_done <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_puf_reset     = r_puf_reset;
  assign bus.o_puf_challenge = r_chal;
  assign bus.o_resp_valid    = r_resp_valid;
  assign bus.o_resp_chal     = r_resp_chal;
  assign bus.o_resp_data     = r_resp_data;
  assign bus.o_resp_err      = r_resp_err;
  assign bus.o_busy          = r_busy;
  assign bus.o_seq_done      = r_seq_done;
  assign bus.o_err           = r_err;
  assign bus.o_signature     = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_puf_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_puf_sequencer
//  Purpose  : Self-checking bench for puf_sequencer. A simple PUF model raises
//             DONE a programmable number of cycles after its reset is
//             released and answers with the inverted challenge. Whole sweeps
//             come from a table; stall, mid-sweep START and reset-in-WAIT are
//             hand-written sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_puf_sequencer;

  localparam int RST_CYC     = 4;
  localparam int TIMEOUT_CYC = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  puf_sequencer_if bus ();

  puf_sequencer #(
    .RST_CYC     (RST_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // --------------------------------------------------------------------------
  // PUF model: DONE becomes visible puf_dly+1 cycles after PUF_RESET falls.
  // --------------------------------------------------------------------------
  int   puf_dly = 10;
  int   pcnt    = 0;
  logic puf_done_q = 1'b0;

  always @(posedge clk) begin
    if (bus.o_puf_reset) begin
      pcnt       <= 0;
      puf_done_q <= 1'b0;
    end else if (pcnt == puf_dly - 1) begin
      puf_done_q <= 1'b1;
    end else begin
      pcnt <= pcnt + 1;
    end
  end

  assign bus.i_puf_done     = puf_done_q;
  assign bus.i_puf_response = ~bus.o_puf_challenge;

  // --------------------------------------------------------------------------
  // Monitor (negedge sampling)
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] chal;
    logic [7:0] data;
    logic       rerr;
    logic       err;
    int         cyc;
  } xfer_t;

  xfer_t q[$];
  xfer_t mon_x;
  int    cyc     = 0;
  int    n_done  = 0;
  int    n_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_resp_valid && bus.i_resp_ready) begin
        mon_x.chal = bus.o_resp_chal;
        mon_x.data = bus.o_resp_data;
        mon_x.rerr = bus.o_resp_err;
        mon_x.err  = bus.o_err;
        mon_x.cyc  = cyc;
        q.push_back(mon_x);
      end
      if (bus.o_seq_done) n_done  = n_done + 1;
      if (bus.o_resp_valid) n_valid = n_valid + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Check helpers
  // --------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {puf_reset, challenge, valid, chal, data, rerr, busy, seq_done, err, sig}
  function automatic logic [63:0] out_vec();
    return 64'({bus.o_puf_reset, bus.o_puf_challenge, bus.o_resp_valid,
                bus.o_resp_chal, bus.o_resp_data, bus.o_resp_err, bus.o_busy,
                bus.o_seq_done, bus.o_err, bus.o_signature});
  endfunction

  localparam logic [63:0] RESET_VEC = 64'({1'b1, 8'h00, 1'b0, 8'h00, 8'h00,
                                           1'b0, 1'b0, 1'b0, 1'b0, 8'h00});

  task automatic start_sweep(input logic [7:0] sc, input logic [7:0] nc);
    bus.i_start_chal = sc;
    bus.i_num_chal   = nc;
    bus.i_start      = 1'b1;
    tick();
    bus.i_start      = 1'b0;
  endtask

  task automatic wait_seq_done(input int base, input int limit);
    for (int k = 0; k < limit && n_done == base; k++) tick();
  endtask

  // --------------------------------------------------------------------------
  // Sweep table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] sc;
    logic [7:0] nc;
    int         dly;
    int         n;
    logic [7:0] sig;
    logic       err;
    int         period;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0]  echal;
    logic [7:0]  edata;
    logic [63:0] snap;
    int          base;
    int          vbase;

    bus.i_start      = 1'b0;
    bus.i_start_chal = 8'h00;
    bus.i_num_chal   = 8'h00;
    bus.i_resp_ready = 1'b1;

    //          sc     nc    dly   n    sig    err  period
    vecs[0] = '{8'h10, 8'd3, 10,   3,   8'hEC, 1'b0, 16};  // nominal
    vecs[1] = '{8'hFE, 8'd3, 10,   3,   8'hFE, 1'b0, 16};  // challenge wrap
    vecs[2] = '{8'h20, 8'd2, 1000, 2,   8'h00, 1'b1, 21};  // PUF never done
    vecs[3] = '{8'h40, 8'd1, 15,   1,   8'hBF, 1'b0, 0};   // DONE on last timeout cycle
    vecs[4] = '{8'h41, 8'd1, 16,   1,   8'h00, 1'b1, 0};   // DONE one cycle too late
    vecs[5] = '{8'h00, 8'd0, 1,    256, 8'h00, 1'b0, 7};   // NUM_CHAL=0 -> 256

    // ---- reset values ----
    #2 rst_n = 1'b0;
    #1 check("async reset values", out_vec(), RESET_VEC);
    tick(); tick();
    check("reset values held", out_vec(), RESET_VEC);
    rst_n = 1'b1;
    #1 check("puf_reset before first edge", 64'(bus.o_puf_reset), 64'(1'b1));
    tick();
    check("puf_reset after first edge", 64'({bus.o_puf_reset, bus.o_busy}), 64'(2'b00));

    // ---- table-driven sweeps ----
    for (int v = 0; v < 6; v++) begin
      q.delete();
      puf_dly = vecs[v].dly;
      base    = n_done;
      start_sweep(vecs[v].sc, vecs[v].nc);
      check($sformatf("v%0d busy", v), 64'(bus.o_busy), 64'(1'b1));
      wait_seq_done(base, 3000);
      tick(); tick();
      check($sformatf("v%0d seq_done pulses", v), 64'(n_done - base), 64'(1));
      check($sformatf("v%0d result count", v), 64'(q.size()), 64'(vecs[v].n));
      check($sformatf("v%0d end status {busy,err,sig}", v),
            64'({bus.o_busy, bus.o_err, bus.o_signature}),
            64'({1'b0, vecs[v].err, vecs[v].sig}));
      for (int i = 0; i < q.size(); i++) begin
        echal = vecs[v].sc + 8'(i);
        edata = vecs[v].err ? 8'h00 : ~echal;
        check($sformatf("v%0d result %0d {chal,data,rerr}", v, i),
              64'({q[i].chal, q[i].data, q[i].rerr}),
              64'({echal, edata, vecs[v].err}));
        if (i > 0)
          check($sformatf("v%0d period %0d", v, i),
                64'(q[i].cyc - q[i-1].cyc), 64'(vecs[v].period));
      end
      if (vecs[v].err && q.size() > 0)
        check($sformatf("v%0d err set at first result", v), 64'(q[0].err), 64'(1'b1));
      for (int k = 0; k < 5; k++) tick();
      check($sformatf("v%0d idle hold {err,sig}", v),
            64'({bus.o_err, bus.o_signature}), 64'({vecs[v].err, vecs[v].sig}));
    end

    // ---- stall in OUT with a START pulse that must be ignored ----
    q.delete();
    puf_dly          = 10;
    bus.i_resp_ready = 1'b0;
    base             = n_done;
    start_sweep(8'h50, 8'd2);
    for (int k = 0; k < 40 && !bus.o_resp_valid; k++) tick();
    snap = 64'({bus.o_resp_valid, bus.o_resp_chal, bus.o_resp_data,
                bus.o_resp_err, bus.o_puf_reset, bus.o_busy});
    check("stall first result", snap,
          64'({1'b1, 8'h50, 8'hAF, 1'b0, 1'b0, 1'b1}));
    for (int k = 0; k < 7; k++) begin
      bus.i_start      = (k == 1);
      bus.i_start_chal = 8'h99;
      bus.i_num_chal   = 8'd5;
      check($sformatf("stall cycle %0d", k),
            64'({bus.o_resp_valid, bus.o_resp_chal, bus.o_resp_data,
                 bus.o_resp_err, bus.o_puf_reset, bus.o_busy}), snap);
      tick();
    end
    bus.i_start      = 1'b0;
    bus.i_resp_ready = 1'b1;
    tick();
    check("resume after ready {valid,puf_reset,challenge}",
          64'({bus.o_resp_valid, bus.o_puf_reset, bus.o_puf_challenge}),
          64'({1'b0, 1'b1, 8'h51}));
    wait_seq_done(base, 200);
    tick();
    check("stall sweep count", 64'(q.size()), 64'(2));
    if (q.size() == 2)
      check("stall second result", 64'({q[1].chal, q[1].data}), 64'({8'h51, 8'hAE}));
    check("stall signature", 64'({bus.o_signature, bus.o_busy}), 64'({8'h01, 1'b0}));

    // ---- reset during WAIT of the second challenge ----
    q.delete();
    base = n_done;
    start_sweep(8'h60, 8'd3);
    for (int k = 0; k < 60 && !(q.size() >= 1 && !bus.o_puf_reset); k++) tick();
    check("in WAIT of challenge 2",
          64'({bus.o_puf_reset, bus.o_busy, bus.o_puf_challenge}),
          64'({1'b0, 1'b1, 8'h61}));
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1 check("reset in WAIT immediate", out_vec(), RESET_VEC);
    tick(); tick();
    rst_n = 1'b1;
    vbase = n_valid;
    for (int k = 0; k < 40; k++) tick();
    check("no result after abandoned sweep",
          64'({n_valid - vbase, n_done - base}), 64'({32'd0, 32'd0}));
    check("idle after abandoned sweep",
          64'({bus.o_busy, bus.o_puf_reset, q.size()}), 64'({1'b0, 1'b0, 32'd1}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
